// File: rtl/alu_codes_pkg.sv
// Register codes shared by the ALU operand select, the control unit and the write-back router.
// Also provides the code-to-pending-bit decode used by the router.
package alu_codes_pkg;

  localparam logic [2:0] CODE_IR  = 3'b001;
  localparam logic [2:0] CODE_IDX = 3'b010;
  localparam logic [2:0] CODE_IDY = 3'b011;
  localparam logic [2:0] CODE_R1  = 3'b100;
  localparam logic [2:0] CODE_R5  = 3'b101;

  // Bit positions of the owned registers inside the pend vector.
  typedef enum logic [1:0] {
    REG_R1  = 2'd0,
    REG_R5  = 2'd1,
    REG_IDX = 2'd2,
    REG_IDY = 2'd3
  } reg_idx_e;

  function automatic logic [3:0] code_onehot(input logic [2:0] code);
    logic [3:0] oh;
    oh = 4'b0000;
    case (code)
      CODE_R1:  oh[REG_R1]  = 1'b1;
      CODE_R5:  oh[REG_R5]  = 1'b1;
      CODE_IDX: oh[REG_IDX] = 1'b1;
      CODE_IDY: oh[REG_IDY] = 1'b1;
      CODE_IR:  oh = 4'b0000;
      default:  oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_wb_router_if.sv
// Write-back request bus between the ALU side (master) and the write-back router (slave).
interface alu_wb_router_if #(
  parameter int unsigned WIDTH = 16
);
  logic             wb_valid;
  logic             wb_ready;
  logic [2:0]       wb_code;
  logic             wb_inc;
  logic [WIDTH-1:0] wb_data;
  logic             wb_hold;

  modport master (
    output wb_valid, wb_code, wb_inc, wb_data, wb_hold,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_code, wb_inc, wb_data, wb_hold,
    output wb_ready
  );
endinterface

// File: rtl/wb_fifo.sv
// Small write-back FIFO; exposes per-slot valid bits and contents so the owner can OR up pend flags.
// The caller never pushes while full and never pops while empty.
module wb_fifo #(
  parameter int unsigned DW    = 20,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DW-1:0]             din,
  output logic [DW-1:0]             dout,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0]          vld,
  output logic [DEPTH-1:0][DW-1:0]  mem
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]             r_wptr;
  logic [AW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;
  logic [DEPTH-1:0]          r_vld;
  logic [DEPTH-1:0][DW-1:0]  r_mem;

  // Pointers, occupancy, slot valid bits and storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      r_mem   <= '0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= din;
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == CW'(0));
  assign dout  = r_mem[r_rptr];
  assign vld   = r_vld;
  assign mem   = r_mem;

endmodule

// File: rtl/alu_wb_router.sv
// Routes ALU results into R1, R5, IDX, IDY through a small FIFO, with pending flags and sticky error.
// Optional macro WB_FWD_EN: an accepted request retires at once when the FIFO is empty and not held.
module alu_wb_router
  import alu_codes_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_wb_router_if.slave    wb,
  output logic [WIDTH-1:0]  r1_q,
  output logic [WIDTH-1:0]  r5_q,
  output logic [WIDTH-1:0]  idx_q,
  output logic [WIDTH-1:0]  idy_q,
  output logic [3:0]        pend,
  output logic              wb_err
);
  localparam int unsigned DW = WIDTH + 4;

  logic                      w_full;
  logic                      w_empty;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_fwd;
  logic                      w_retire;
  logic [DW-1:0]             w_in_entry;
  logic [DW-1:0]             w_head;
  logic [DW-1:0]             w_ret_entry;
  logic [DEPTH-1:0]          w_vld;
  logic [DEPTH-1:0][DW-1:0]  w_mem;
  logic [3:0]                w_pend;

  logic [WIDTH-1:0]          r_r1;
  logic [WIDTH-1:0]          r_r5;
  logic [WIDTH-1:0]          r_idx;
  logic [WIDTH-1:0]          r_idy;
  logic                      r_err;

  assign wb.wb_ready = !w_full;
  assign w_accept    = wb.wb_valid && !w_full;
  assign w_pop       = !w_empty && !wb.wb_hold;
  assign w_in_entry  = {wb.wb_code, wb.wb_inc, wb.wb_data};

`ifdef WB_FWD_EN
  assign w_fwd = w_accept && w_empty && !wb.wb_hold;
`else
  assign w_fwd = 1'b0;
`endif

  // A forwarded request bypasses the FIFO entirely, so it never shows up in pend.
  assign w_push      = w_accept && !w_fwd;
  assign w_retire    = w_pop || w_fwd;
  assign w_ret_entry = w_fwd ? w_in_entry : w_head;

  wb_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_in_entry),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .vld   (w_vld),
    .mem   (w_mem)
  );

  // Register file update from the retiring entry; invalid codes only set the sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r1  <= '0;
      r_r5  <= '0;
      r_idx <= '0;
      r_idy <= '0;
      r_err <= 1'b0;
    end else if (w_retire) begin
      case (w_ret_entry[DW-1:WIDTH+1])
        CODE_R1:  r_r1  <= w_ret_entry[WIDTH] ? r_r1  + WIDTH'(1) : w_ret_entry[WIDTH-1:0];
        CODE_R5:  r_r5  <= w_ret_entry[WIDTH] ? r_r5  + WIDTH'(1) : w_ret_entry[WIDTH-1:0];
        CODE_IDX: r_idx <= w_ret_entry[WIDTH] ? r_idx + WIDTH'(1) : w_ret_entry[WIDTH-1:0];
        CODE_IDY: r_idy <= w_ret_entry[WIDTH] ? r_idy + WIDTH'(1) : w_ret_entry[WIDTH-1:0];
        default:  r_err <= 1'b1;
      endcase
    end
  end

  // Pending flags: OR of destination bits over occupied FIFO slots.
  always_comb begin
    w_pend = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_vld[i]) begin
        w_pend = w_pend | code_onehot(w_mem[i][DW-1:WIDTH+1]);
      end else begin
        w_pend = w_pend;
      end
    end
  end

  assign r1_q   = r_r1;
  assign r5_q   = r_r5;
  assign idx_q  = r_idx;
  assign idy_q  = r_idy;
  assign pend   = w_pend;
  assign wb_err = r_err;

endmodule

// File: tb/tb_alu_wb_router.sv
// Self-checking bench for alu_wb_router: directed scenarios plus randomized traffic against a queue model.
module tb_alu_wb_router;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 2;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  code;
    logic        inc;
    logic [15:0] data;
  } req_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] r1_q, r5_q, idx_q, idy_q;
  logic [3:0]  pend;
  logic        wb_err;

  alu_wb_router_if #(.WIDTH(WIDTH)) bus ();

  alu_wb_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wb     (bus.slave),
    .r1_q   (r1_q),
    .r5_q   (r5_q),
    .idx_q  (idx_q),
    .idy_q  (idy_q),
    .pend   (pend),
    .wb_err (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  req_t m_q[$];
  logic [15:0] m_reg [4];
  logic m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Destination index from the register-code table: 0=R1 1=R5 2=IDX 3=IDY, -1 invalid.
  function automatic int dest_of(input logic [2:0] code);
    if (code == 3'b100) return 0;
    if (code == 3'b101) return 1;
    if (code == 3'b010) return 2;
    if (code == 3'b011) return 3;
    return -1;
  endfunction

  task automatic model_apply(input req_t r);
    int d;
    d = dest_of(r.code);
    if (d < 0) m_err = 1'b1;
    else m_reg[d] = r.inc ? m_reg[d] + 16'd1 : r.data;
  endtask

  task automatic model_edge();
    req_t in_r;
    bit   acc, fwd;
    if (!rst_n) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
      m_err = 1'b0;
    end else begin
      in_r = '{code: bus.wb_code, inc: bus.wb_inc, data: bus.wb_data};
      acc  = bus.wb_valid && (m_q.size() < DEPTH);
      fwd  = FWD && acc && (m_q.size() == 0) && !bus.wb_hold;
      if (m_q.size() > 0 && !bus.wb_hold) model_apply(m_q.pop_front());
      if (fwd) model_apply(in_r);
      else if (acc) m_q.push_back(in_r);
    end
  endtask

  function automatic logic [3:0] model_pend();
    logic [3:0] p;
    int d;
    p = 4'b0000;
    foreach (m_q[i]) begin
      d = dest_of(m_q[i].code);
      if (d >= 0) p[d] = 1'b1;
    end
    return p;
  endfunction

  // One clock: update the model at the rising edge, compare everything at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("r1_q",     {16'h0, r1_q},  {16'h0, m_reg[0]});
    check_eq("r5_q",     {16'h0, r5_q},  {16'h0, m_reg[1]});
    check_eq("idx_q",    {16'h0, idx_q}, {16'h0, m_reg[2]});
    check_eq("idy_q",    {16'h0, idy_q}, {16'h0, m_reg[3]});
    check_eq("pend",     {28'h0, pend},  {28'h0, model_pend()});
    check_eq("wb_ready", {31'h0, bus.wb_ready}, {31'h0, (m_q.size() < DEPTH)});
    check_eq("wb_err",   {31'h0, wb_err}, {31'h0, m_err});
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic i, input logic [15:0] d,
                       input logic h);
    bus.wb_valid = v;
    bus.wb_code  = c;
    bus.wb_inc   = i;
    bus.wb_data  = d;
    bus.wb_hold  = h;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
    m_err = 1'b0;
    cycle();
    cycle();
    check_eq("reset_ready", {31'h0, bus.wb_ready}, 32'd1);
    check_eq("reset_pend",  {28'h0, pend}, 32'd0);
    rst_n = 1'b1;

    // Load R1, pend pulses for one cycle in the queued build.
    drive(1'b1, 3'b100, 1'b0, 16'h1234, 1'b0);
    cycle();
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 1'b0);
    cycle();
    check_eq("t1_r1", {16'h0, r1_q}, 32'h1234);
    cycle();

    // IDX wraps from 0xFFFF to 0 on increment.
    drive(1'b1, 3'b010, 1'b0, 16'hFFFF, 1'b0);
    cycle();
    drive(1'b1, 3'b010, 1'b1, 16'hABCD, 1'b0);
    cycle();
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 1'b0);
    cycle();
    cycle();
    check_eq("t2_idx", {16'h0, idx_q}, 32'h0000);
    check_eq("t2_err", {31'h0, wb_err}, 32'd0);

    // Held FIFO fills up, then drains in order.
    drive(1'b1, 3'b101, 1'b0, 16'h000A, 1'b1);
    cycle();
    drive(1'b1, 3'b011, 1'b0, 16'h000B, 1'b1);
    cycle();
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 1'b1);
    check_eq("t3_ready_full", {31'h0, bus.wb_ready}, 32'd0);
    check_eq("t3_pend", {28'h0, pend}, 32'b1010);
    cycle();
    check_eq("t3_held_r5", {16'h0, r5_q}, 32'h0000);
    bus.wb_hold = 1'b0;
    cycle();
    check_eq("t3_r5", {16'h0, r5_q}, 32'h000A);
    check_eq("t3_idy_pending", {16'h0, idy_q}, 32'h0000);
    cycle();
    check_eq("t3_idy", {16'h0, idy_q}, 32'h000B);
    check_eq("t3_ready", {31'h0, bus.wb_ready}, 32'd1);

    // Invalid code sets the sticky error.
    drive(1'b1, 3'b001, 1'b0, 16'h5555, 1'b0);
    cycle();
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 1'b0);
    cycle();
    cycle();
    check_eq("t4_err", {31'h0, wb_err}, 32'd1);
    check_eq("t4_r1_kept", {16'h0, r1_q}, 32'h1234);

    // Reset with queued requests discards them.
    drive(1'b1, 3'b100, 1'b0, 16'hBEEF, 1'b1);
    cycle();
    drive(1'b1, 3'b101, 1'b0, 16'hCAFE, 1'b1);
    cycle();
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    bus.wb_hold = 1'b0;
    check_eq("t5_r1", {16'h0, r1_q}, 32'h0000);
    check_eq("t5_pend", {28'h0, pend}, 32'd0);
    check_eq("t5_ready", {31'h0, bus.wb_ready}, 32'd1);
    check_eq("t5_err", {31'h0, wb_err}, 32'd0);
    cycle();
    check_eq("t5_no_late_write", {16'h0, r5_q}, 32'h0000);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
            16'($urandom), ($urandom_range(0, 9) < 3));
      if ($urandom_range(0, 15) == 0) bus.wb_data = 16'hFFFF;
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
